// File: rtl/ram_dma.sv
// Single-channel copy/fill engine that drives a synchronous RAM port.
// Copy alternates read and write cycles; fill writes one byte per cycle.
module ram_dma #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_val,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_FILL,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_fill;
  logic              r_busy;
  logic              r_done;
  logic              r_rd;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;

  logic              w_last;
  logic [ADDR_W-1:0] w_src_nxt;
  logic [ADDR_W-1:0] w_dst_nxt;

  assign w_last    = (r_cnt == LEN_W'(1));
  assign w_src_nxt = r_src + ADDR_W'(1);
  assign w_dst_nxt = r_dst + ADDR_W'(1);

  // Outputs are registered as the next state is chosen, so strobes, address
  // and busy never depend combinationally on start or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_fill  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
          r_rd   <= 1'b0;
          r_wr   <= 1'b0;
          if (start) begin
            r_src  <= src;
            r_dst  <= dst;
            r_cnt  <= len;
            r_fill <= fill_val;
            if (len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (mode) begin
              r_state <= S_FILL;
              r_busy  <= 1'b1;
              r_wr    <= 1'b1;
              r_addr  <= dst;
            end else begin
              r_state <= S_RD;
              r_busy  <= 1'b1;
              r_rd    <= 1'b1;
              r_addr  <= src;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RD: begin
          r_state <= S_WR;
          r_rd    <= 1'b0;
          r_wr    <= 1'b1;
          r_addr  <= r_dst;
        end
        S_WR: begin
          r_src <= w_src_nxt;
          r_dst <= w_dst_nxt;
          r_cnt <= r_cnt - LEN_W'(1);
          r_wr  <= 1'b0;
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_RD;
            r_rd    <= 1'b1;
            r_addr  <= w_src_nxt;
          end
        end
        S_FILL: begin
          r_dst <= w_dst_nxt;
          r_cnt <= r_cnt - LEN_W'(1);
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_wr    <= 1'b0;
          end else begin
            r_addr <= w_dst_nxt;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_rd    <= 1'b0;
          r_wr    <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign mem_rd   = r_rd;
  assign mem_wr   = r_wr;
  assign mem_addr = r_addr;
  // Copy data flows straight from the RAM's registered output to its input.
  assign mem_din  = (r_state == S_WR) ? mem_dout : r_fill;

endmodule

// File: tb/tb_ram_dma.sv
// Bench for ram_dma: behavioural RAM, byte-level reference image and
// per-cycle expectations derived from the transfer rules.
module tb_ram_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] src = '0;
  logic [15:0] dst = '0;
  logic [15:0] len = '0;
  logic [7:0]  fill_val = '0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout = '0;

  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  int vectors = 0;
  int miscompares = 0;

  bit [7:0] ram   [0:65535];
  bit [7:0] model [0:65535];

  ram_dma #(.ADDR_W(16), .DATA_W(8), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .abort(abort), .busy(busy), .done(done),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Background pattern: RAM cells hold data XOR bg(addr), so the initial image is bg().
  function automatic logic [7:0] bg(input logic [15:0] a);
    logic [7:0] t;
    t = a[7:0] * 8'd37;
    return t ^ a[15:8] ^ 8'h5C;
  endfunction

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data ^ bg(pl_addr);
    if (mem_wr) ram[mem_addr] <= mem_din ^ bg(mem_addr);
    if (mem_rd) mem_dout <= ram[mem_addr] ^ bg(mem_addr);
  end

  function automatic logic [7:0] rd_ram(input logic [15:0] a);
    return ram[a] ^ bg(a);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] v);
    pl_addr = a;
    pl_data = v;
    pl_en   = 1'b1;
    step();
    pl_en   = 1'b0;
    model[a] = v;
  endtask

  // Issue one command and check every cycle until done (or the stop cycle).
  task automatic xfer(input logic m, input logic [15:0] s, input logic [15:0] d,
                      input logic [15:0] n, input logic [7:0] fv,
                      input int poke_at, input int stop_at, input bit use_rst);
    int total;
    int i;
    logic [15:0] a;
    logic [7:0] exp_din;
    bit er;
    bit ew;
    mode = m; src = s; dst = d; len = n; fill_val = fv; start = 1'b1;
    step();
    start = 1'b0;
    src = 16'($urandom); dst = 16'($urandom); len = 16'($urandom);
    fill_val = 8'($urandom); mode = 1'($urandom);
    total = (n == 16'd0) ? 0 : (m ? int'(n) : 2 * int'(n));
    for (int c = 1; c <= total; c++) begin
      if (c == poke_at) start = 1'b1;
      if (m) begin
        i = c - 1; er = 1'b0; ew = 1'b1;
        a = d + 16'(i);
        exp_din = fv;
      end else begin
        i = (c - 1) / 2;
        er = (c % 2 == 1);
        ew = !er;
        a = er ? s + 16'(i) : d + 16'(i);
        exp_din = ew ? model[s + 16'(i)] : fv;
      end
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      chk("mem_rd", mem_rd, er);
      chk("mem_wr", mem_wr, ew);
      chk("mem_addr", mem_addr, a);
      chk("mem_din", mem_din, exp_din);
      if (ew) model[a] = exp_din;
      if (c == stop_at) begin
        if (use_rst) rst = 1'b1; else abort = 1'b1;
        step();
        rst = 1'b0; abort = 1'b0; start = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_done", done, 0);
        chk("stop_rd", mem_rd, 0);
        chk("stop_wr", mem_wr, 0);
        if (use_rst) begin
          chk("rst_addr", mem_addr, 0);
          chk("rst_din", mem_din, 0);
        end
        step();
        chk("stop_busy2", busy, 0);
        chk("stop_done2", done, 0);
        return;
      end
      step();
      start = 1'b0;
    end
    chk("fin_busy", busy, 0);
    chk("fin_done", done, 1);
    chk("fin_rd", mem_rd, 0);
    chk("fin_wr", mem_wr, 0);
    chk("fin_din", mem_din, fv);
  endtask

  initial begin
    logic        rm;
    logic [15:0] rs;
    logic [15:0] rdst;
    logic [15:0] rn;
    logic [7:0]  rf;
    int          rp;
    int          bad;
    for (int k = 0; k < 65536; k++) model[k] = bg(16'(k));

    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_wr", mem_wr, 0);
    chk("rst_addr0", mem_addr, 0);
    chk("rst_din0", mem_din, 0);
    rst = 1'b0;
    step();

    xfer(1'b1, 16'h0000, 16'h0100, 16'd4, 8'hA5, 0, 0, 1'b0);
    step();
    for (int k = 0; k < 4; k++) chk("fill_rb", rd_ram(16'h0100 + 16'(k)), 8'hA5);
    chk("fill_below", rd_ram(16'h00FF), model[16'h00FF]);
    chk("fill_above", rd_ram(16'h0104), model[16'h0104]);

    poke(16'h0200, 8'h11);
    poke(16'h0201, 8'h22);
    poke(16'h0202, 8'h33);
    xfer(1'b0, 16'h0200, 16'h0300, 16'd3, 8'h00, 0, 0, 1'b0);
    step();
    chk("copy_rb0", rd_ram(16'h0300), 8'h11);
    chk("copy_rb1", rd_ram(16'h0301), 8'h22);
    chk("copy_rb2", rd_ram(16'h0302), 8'h33);

    xfer(1'b1, 16'h0000, 16'hFFFF, 16'd3, 8'h5A, 0, 0, 1'b0);
    step();
    chk("wrap_ffff", rd_ram(16'hFFFF), 8'h5A);
    chk("wrap_0000", rd_ram(16'h0000), 8'h5A);
    chk("wrap_0001", rd_ram(16'h0001), 8'h5A);
    chk("wrap_0002", rd_ram(16'h0002), model[16'h0002]);

    poke(16'h0400, 8'h7E);
    xfer(1'b0, 16'h0400, 16'h0401, 16'd3, 8'h3C, 0, 0, 1'b0);
    step();
    for (int k = 1; k <= 3; k++) chk("overlap_rb", rd_ram(16'h0400 + 16'(k)), 8'h7E);

    xfer(1'b1, 16'h0000, 16'h0600, 16'd0, 8'h77, 0, 0, 1'b0);
    step();
    chk("len0_busy", busy, 0);
    chk("len0_done_clr", done, 0);
    chk("len0_untouched", rd_ram(16'h0600), model[16'h0600]);

    xfer(1'b1, 16'h0000, 16'h0700, 16'd6, 8'hC3, 2, 0, 1'b0);
    step();
    for (int k = 0; k < 6; k++) chk("ign_rb", rd_ram(16'h0700 + 16'(k)), 8'hC3);
    chk("ign_above", rd_ram(16'h0706), model[16'h0706]);

    for (int k = 0; k < 10; k++) poke(16'h0800 + 16'(k), 8'hEE);
    xfer(1'b1, 16'h0000, 16'h0800, 16'd10, 8'h99, 0, 3, 1'b0);
    for (int k = 0; k < 3; k++) chk("abort_wr", rd_ram(16'h0800 + 16'(k)), 8'h99);
    for (int k = 3; k < 10; k++) chk("abort_untouched", rd_ram(16'h0800 + 16'(k)), 8'hEE);

    xfer(1'b0, 16'h0200, 16'h0900, 16'd3, 8'h44, 0, 3, 1'b1);
    chk("rst_partial", rd_ram(16'h0900), 8'h11);
    chk("rst_nowr", rd_ram(16'h0901), model[16'h0901]);

    mode = 1'b1; dst = 16'h0C00; len = 16'd5; fill_val = 8'h21;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("prio_busy", busy, 0);
    chk("prio_wr", mem_wr, 0);
    step();
    chk("prio_busy2", busy, 0);

    xfer(1'b1, 16'h0000, 16'h0A00, 16'd2, 8'h12, 0, 0, 1'b0);
    xfer(1'b0, 16'h0A00, 16'h0B00, 16'd2, 8'h00, 0, 0, 1'b0);
    step();
    chk("b2b_rb0", rd_ram(16'h0B00), 8'h12);
    chk("b2b_rb1", rd_ram(16'h0B01), 8'h12);

    for (int r = 0; r < 25; r++) begin
      rm = 1'($urandom);
      rs = 16'($urandom);
      rdst = 16'($urandom);
      rn = 16'($urandom_range(0, 12));
      rf = 8'($urandom);
      rp = $urandom_range(0, 3) == 0 ? $urandom_range(1, 24) : 0;
      xfer(rm, rs, rdst, rn, rf, rp, 0, 1'b0);
      if ($urandom_range(0, 1) == 1) step();
    end
    step();

    bad = 0;
    for (int k = 0; k < 65536; k++) if (rd_ram(16'(k)) !== model[k]) bad++;
    chk("ram_image", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
